// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, 1-cycle-latency memory between instruction fetch (IF) and load/store (DM).
// Optional macro ARB_RR_EN: round-robin on contention; when undefined, DM has fixed priority over IF.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [CNT_W-1:0]  contend_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    owner_t           owner_q, owner_d;
    logic             store_q, store_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             contend;
    logic             grant_if, grant_dm;

    assign contend = if_req & dm_req;

`ifdef ARB_RR_EN
    // rr_dm_q = 1 means DM is preferred at the next contention, 0 means IF.
    logic rr_dm_q, rr_dm_d;

    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        rr_dm_d  = rr_dm_q;
        if (contend) begin
            grant_dm = rr_dm_q;
            grant_if = ~rr_dm_q;
            rr_dm_d  = ~rr_dm_q;
        end else begin
            grant_if = if_req;
            grant_dm = dm_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_dm_q <= 1'b0;
        end else begin
            rr_dm_q <= rr_dm_d;
        end
    end
`else
    always_comb begin
        grant_dm = dm_req;
        grant_if = if_req & ~dm_req;
    end
`endif

    // No grant while reset is asserted, so nothing reaches the memory mid-reset.
    assign if_gnt = grant_if & ~rst;
    assign dm_gnt = grant_dm & ~rst;

    always_comb begin
        owner_d = OWN_NONE;
        store_d = 1'b0;
        cnt_d   = cnt_q;
        if (dm_gnt) begin
            owner_d = OWN_DM;
            store_d = dm_we;
        end else if (if_gnt) begin
            owner_d = OWN_IF;
        end
        if (contend && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            store_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_en    = if_gnt | dm_gnt;
    assign mem_we    = dm_gnt & dm_we;
    assign mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = mem_we ? dm_wdata : '0;

    // A response owed across a reset cycle is dropped rather than delivered.
    assign if_rvalid = ~rst & (owner_q == OWN_IF);
    assign dm_rvalid = ~rst & (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid & ~store_q) ? mem_rdata : '0;

    assign contend_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] contend_cnt;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .contend_cnt(contend_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h00A00513;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Memory macro: single port, registered read, contents default to init_word until written.
    bit [31:0] mac_mem [256];
    bit        mac_wr  [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mac_mem[mem_addr[9:2]] <= mem_wdata;
                mac_wr[mem_addr[9:2]]  <= 1'b1;
            end else begin
                mem_rdata <= mac_wr[mem_addr[9:2]] ? mac_mem[mem_addr[9:2]] : init_word(mem_addr);
            end
        end
    end

    // Reference model: expected memory contents and the response owed next cycle.
    bit [31:0]   sh_mem [256];
    bit          sh_wr  [256];
    int          exp_owner;   // 0 none, 1 fetch, 2 data
    logic [31:0] exp_data;
    int          exp_cnt;
    bit          pref_dm;     // side favoured at the next contention (round-robin only)
    bit          got_if, got_dm;

    function automatic logic [31:0] sh_read(input logic [31:0] a);
        return sh_wr[a[9:2]] ? sh_mem[a[9:2]] : init_word(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the currently driven inputs: check mid-cycle, advance model, return at edge+1.
    task automatic step();
        bit e_if, e_dm, both, rv_if, rv_dm;
        @(negedge clk);
        n_vec++;
        both = if_req && dm_req;
        e_if = 1'b0;
        e_dm = 1'b0;
        if (!rst) begin
            if (both) begin
                if (RR && !pref_dm) e_if = 1'b1;
                else                e_dm = 1'b1;
            end else begin
                e_if = if_req;
                e_dm = dm_req;
            end
        end
        rv_if = !rst && exp_owner == 1;
        rv_dm = !rst && exp_owner == 2;
        chk("if_gnt", if_gnt, e_if);
        chk("dm_gnt", dm_gnt, e_dm);
        chk("mem_en", mem_en, e_if | e_dm);
        chk("mem_we", mem_we, e_dm & dm_we);
        if (e_dm)      chk("mem_addr", mem_addr, dm_addr);
        else if (e_if) chk("mem_addr", mem_addr, if_addr);
        if (e_dm && dm_we) chk("mem_wdata", mem_wdata, dm_wdata);
        chk("if_rvalid", if_rvalid, rv_if);
        chk("if_rdata", if_rdata, rv_if ? exp_data : 32'h0);
        chk("dm_rvalid", dm_rvalid, rv_dm);
        chk("dm_rdata", dm_rdata, rv_dm ? exp_data : 32'h0);
        chk("contend_cnt", 32'(contend_cnt), rst ? 32'h0 : 32'(exp_cnt));

        got_if = e_if;
        got_dm = e_dm;
        if (rst) begin
            exp_owner = 0;
            exp_data  = 32'h0;
            exp_cnt   = 0;
            pref_dm   = 1'b0;
        end else begin
            if (both) begin
                if (exp_cnt < CMAX) exp_cnt++;
                pref_dm = e_if;   // the loser is favoured next time
            end
            if (e_dm) begin
                exp_owner = 2;
                if (dm_we) begin
                    sh_mem[dm_addr[9:2]] = dm_wdata;
                    sh_wr[dm_addr[9:2]]  = 1'b1;
                    exp_data = 32'h0;
                end else begin
                    exp_data = sh_read(dm_addr);
                end
            end else if (e_if) begin
                exp_owner = 1;
                exp_data  = sh_read(if_addr);
            end else begin
                exp_owner = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        exp_owner = 0; exp_data = '0; exp_cnt = 0; pref_dm = 1'b0;
        got_if = 1'b0; got_dm = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        repeat (5) step();

        // Single fetch
        if_req = 1'b1; if_addr = 32'h10;
        step();
        if_req = 1'b0;
        chk("t2_fetch_data", if_rdata, 32'h00A00513);
        step();

        // Store then load to the same word
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
        step();
        dm_we = 1'b0;
        step();
        dm_req = 1'b0;
        chk("t3_load_data", dm_rdata, 32'hDEADBEEF);
        step();

        // Sustained contention, then counter saturation
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        repeat (4) step();
        chk("t4_contend_cnt", 32'(contend_cnt), 32'd4);
        repeat (16) step();
        chk("t5_contend_sat", 32'(contend_cnt), 32'd15);
        if_req = 1'b0; dm_req = 1'b0;
        step();

        // Reset in the response cycle of a load
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        step();
        dm_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();

        // Random traffic: requests held until granted, occasional resets
        repeat (400) begin
            rst = 1'b0;
            if (got_if || !if_req) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (got_dm || !dm_req) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = 32'($urandom_range(0, 15)) << 2;
                dm_wdata = $urandom;
            end
            if ($urandom_range(0, 49) == 0) rst = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
